// File: rtl/lsu_access.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// lsu_access
//   Load/store access unit of the RV64 core. Accepts one decoded memory access
//   at a time, issues a single aligned doubleword request on the data-memory
//   port, then hands sign/zero-extended load data (or a status-only result
//   for stores, errors and no-ops) to writeback over a valid/ready handshake.
//
// Parameters
//   RESP_TIMEOUT  cycles to wait for dmem_gnt / dmem_rvalid before aborting
//                 with out_err (1..255, counter is 8 bits)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake (in_ready only in IDLE)
//   mem_read, mem_write        access kind from the decoder
//   load_type, store_type      width/sign encodings from the decoder
//   addr, wdata                effective byte address, LSB-justified store data
//   out_valid / out_ready      result handshake
//   out_rdata                  extended load data, 0 for anything else
//   out_misalign, out_err      mutually exclusive status flags
//   dmem_req/we/addr/wdata/wmask  data-memory request, held until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata  data-memory handshake and read data
// ----------------------------------------------------------------------------
module lsu_access #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_misalign,
    output logic        out_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wmask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LH  = 3'b010;
    localparam logic [2:0] LT_LW  = 3'b011;
    localparam logic [2:0] LT_LD  = 3'b100;
    localparam logic [2:0] LT_LBU = 3'b101;
    localparam logic [2:0] LT_LHU = 3'b110;
    localparam logic [2:0] LT_LWU = 3'b111;

    // Last count value before the wait is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [7:0]  tmo_cnt;
    logic        is_load_q;
    logic [2:0]  ltype_q;
    logic [2:0]  sh_q;

    logic        acc_illegal;
    logic        acc_misalign;
    logic [1:0]  acc_size;      // log2 of access width in bytes
    logic [7:0]  base_mask;
    logic        timeout_hit;
    logic [63:0] rd_shifted;
    logic [63:0] load_ext;

    // Handshake and request strobes come straight from the state register so
    // that an asynchronous reset drops dmem_req in the same cycle.
    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign dmem_req    = (state == S_REQ);
    assign timeout_hit = (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------
    // Decode of the incoming request
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default at the top,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        acc_illegal  = 1'b0;
        acc_size     = 2'd0;
        acc_misalign = 1'b0;
        if (mem_read && mem_write) begin
            acc_illegal = 1'b1;
        end else if (mem_read) begin
            acc_illegal = (load_type == 3'b000);
            // 001/101 -> byte, 010/110 -> half, 011/111 -> word, 100 -> double
            acc_size    = (load_type == LT_LD) ? 2'd3 : (load_type[1:0] - 2'd1);
        end else if (mem_write) begin
            // Only 100..111 are store encodings; anything else is illegal.
            acc_illegal = !store_type[2];
            acc_size    = store_type[1:0];
        end

        case (acc_size)
            2'd1:    acc_misalign = addr[0];
            2'd2:    acc_misalign = |addr[1:0];
            2'd3:    acc_misalign = |addr[2:0];
            default: acc_misalign = 1'b0;
        endcase

        case (acc_size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction from the aligned doubleword
    // ------------------------------------------------------------------
    always_comb begin
        rd_shifted = dmem_rdata >> {sh_q, 3'b000};
        case (ltype_q)
            LT_LB:   load_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            LT_LH:   load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            LT_LW:   load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            LT_LD:   load_ext = rd_shifted;
            LT_LBU:  load_ext = {56'd0, rd_shifted[7:0]};
            LT_LHU:  load_ext = {48'd0, rd_shifted[15:0]};
            LT_LWU:  load_ext = {32'd0, rd_shifted[31:0]};
            default: load_ext = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    // Errors, no-ops and misaligned accesses never touch memory.
                    if (acc_illegal || !(mem_read || mem_write) || acc_misalign)
                        state_d = S_DONE;
                    else
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt)
                    state_d = is_load_q ? S_RESP : S_DONE;
                else if (timeout_hit)
                    state_d = S_DONE;
            end
            S_RESP: begin
                if (dmem_rvalid || timeout_hit)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request and result registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            is_load_q    <= 1'b0;
            ltype_q      <= '0;
            sh_q         <= '0;
            out_rdata    <= '0;
            out_misalign <= 1'b0;
            out_err      <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wmask   <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        is_load_q    <= mem_read && !mem_write;
                        ltype_q      <= load_type;
                        sh_q         <= addr[2:0];
                        out_rdata    <= '0;
                        out_err      <= acc_illegal;
                        out_misalign <= !acc_illegal && acc_misalign;
                        tmo_cnt      <= '0;
                        dmem_addr    <= {addr[63:3], 3'b000};
                        dmem_we      <= mem_write && !mem_read;
                        dmem_wdata   <= mem_write ? (wdata << {addr[2:0], 3'b000}) : '0;
                        dmem_wmask   <= mem_write ? (base_mask << addr[2:0]) : '0;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        tmo_cnt <= '0;          // fresh budget for the response
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (timeout_hit)
                            out_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        out_rdata <= load_ext;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (timeout_hit)
                            out_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
`timescale 1ns/1ps
// Self-checking bench for lsu_access: a table of single accesses run through a
// memory responder and result scoreboard, plus hand-written sequences for
// stalls, timeouts and reset in the middle of a request.
module tb_lsu_access;

    localparam logic [2:0] LB = 3'b001, LH = 3'b010, LW = 3'b011, LD = 3'b100;
    localparam logic [2:0] LBU = 3'b101, LHU = 3'b110, LWU = 3'b111;
    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, SD = 3'b111, NO = 3'b000;
    localparam logic [63:0] R  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] R1 = 64'h80AB_CDEF_0123_4567;
    localparam logic [63:0] Z  = 64'h0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  lt;
        logic [2:0]  st;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrdata;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_rdata;
        logic        exp_mis;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        err;
    } out_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, mem_read, mem_write;
    logic [2:0]  load_type, store_type;
    logic [63:0] addr, wdata;
    logic        out_valid, out_ready, out_misalign, out_err;
    logic [63:0] out_rdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wmask;

    // Second instance with a short timeout, driven by hand.
    logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_misalign, t_out_err;
    logic [63:0] t_out_rdata;
    logic        t_dmem_req, t_dmem_we, t_dmem_gnt, t_dmem_rvalid;
    logic [63:0] t_dmem_addr, t_dmem_wdata, t_dmem_rdata;
    logic [7:0]  t_dmem_wmask;

    int          n_checks = 0;
    int          n_errors = 0;
    string       cur_name = "reset";
    out_t        exp_q[$];
    req_t        req_q[$];
    vec_t        vecs[$];
    int          gnt_wait = 0;
    int          wait_cnt = 0;
    bit          rv_due = 1'b0;
    int          req_cycles = 0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    lsu_access dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
        .addr(addr), .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_misalign(out_misalign), .out_err(out_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    lsu_access #(.RESP_TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
        .addr(addr), .wdata(wdata), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_rdata(t_out_rdata), .out_misalign(t_out_misalign), .out_err(t_out_err),
        .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr), .dmem_wdata(t_dmem_wdata),
        .dmem_wmask(t_dmem_wmask), .dmem_gnt(t_dmem_gnt), .dmem_rvalid(t_dmem_rvalid), .dmem_rdata(t_dmem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%s]: got 0x%0h, want 0x%0h", name, cur_name, act, exp);
        end
    endtask

    // Memory responder and result monitor, both sampling on the falling edge.
    always @(negedge clk) begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
            rv_due   = 1'b0;
        end else begin
            if (rv_due) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_rdata;
                rv_due      = 1'b0;
            end
            if (dmem_req) begin
                req_cycles++;
                if (req_q.size() == 0) begin
                    check("unexpected dmem_req", dmem_req, 1'b0);
                end else begin
                    check("dmem_addr", dmem_addr, req_q[0].addr);
                    check("dmem_we", dmem_we, req_q[0].we);
                    if (req_q[0].we) begin
                        check("dmem_wdata", dmem_wdata, req_q[0].wdata);
                        check("dmem_wmask", dmem_wmask, req_q[0].wmask);
                    end
                    if (wait_cnt >= gnt_wait) begin
                        dmem_gnt = 1'b1;
                        wait_cnt = 0;
                        rv_due   = !req_q[0].we;
                        void'(req_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", out_valid, 1'b0);
                end else begin
                    check("out_rdata", out_rdata, exp_q[0].rdata);
                    check("out_misalign", out_misalign, exp_q[0].mis);
                    check("out_err", out_err, exp_q[0].err);
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one request; called #1 after a rising edge, returns #1 after the
    // edge that accepted it.
    task automatic send(input vec_t v);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        cur_name = v.name;
        check("in_ready before send", in_ready, 1'b1);
        mem_read   = v.rd;
        mem_write  = v.wr;
        load_type  = v.lt;
        store_type = v.st;
        addr       = v.addr;
        wdata      = v.wdata;
        mem_rdata  = v.mrdata;
        exp_q.push_back('{v.exp_rdata, v.exp_mis, v.exp_err});
        if (v.exp_req)
            req_q.push_back('{v.exp_addr, v.wr && !v.rd, v.exp_wdata, v.exp_wmask});
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid seen", out_valid, 1'b1);
        if (exp_lat > 0)
            check("latency", lat, exp_lat);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("return to idle", in_ready, 1'b1);
    endtask

    task automatic t_wait_valid(output int n);
        n = 0;
        while (!t_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        load_type = NO; store_type = NO; addr = '0; wdata = '0;
        out_ready = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        t_in_valid = 1'b0; t_out_ready = 1'b1; t_dmem_gnt = 1'b0; t_dmem_rvalid = 1'b0; t_dmem_rdata = '0;

        //            name     rd    wr    lt   st   addr          wdata                   mrdata req  exp_addr      exp_wdata                 wmask  exp_rdata                 mis   err   lat
        vecs.push_back('{"lb",   1'b1, 1'b0, LB,  NO, 64'h1007, Z, R1, 1'b1, 64'h1000, Z, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 3});
        vecs.push_back('{"lbu",  1'b1, 1'b0, LBU, NO, 64'h1007, Z, R1, 1'b1, 64'h1000, Z, 8'h00, 64'h80, 1'b0, 1'b0, 3});
        vecs.push_back('{"sh",   1'b0, 1'b1, NO,  SH, 64'h2002, 64'h1234, Z, 1'b1, 64'h2000, 64'h0000_0000_1234_0000, 8'h0C, Z, 1'b0, 1'b0, 2});
        vecs.push_back('{"lw mis", 1'b1, 1'b0, LW, NO, 64'h3006, Z, R, 1'b0, Z, Z, 8'h00, Z, 1'b1, 1'b0, 1});
        vecs.push_back('{"sd mis", 1'b0, 1'b1, NO, SD, 64'h3004, 64'h55, Z, 1'b0, Z, Z, 8'h00, Z, 1'b1, 1'b0, 1});
        vecs.push_back('{"rd+wr", 1'b1, 1'b1, LD, SD, 64'h4000, 64'h77, R, 1'b0, Z, Z, 8'h00, Z, 1'b0, 1'b1, 1});
        vecs.push_back('{"noop", 1'b0, 1'b0, LD, SD, 64'h4000, 64'h77, R, 1'b0, Z, Z, 8'h00, Z, 1'b0, 1'b0, 1});
        vecs.push_back('{"lh",   1'b1, 1'b0, LH,  NO, 64'h1006, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'hFFFF_FFFF_FFFF_FEDC, 1'b0, 1'b0, 3});
        vecs.push_back('{"lhu",  1'b1, 1'b0, LHU, NO, 64'h1004, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'h0000_0000_0000_BA98, 1'b0, 1'b0, 3});
        vecs.push_back('{"lw",   1'b1, 1'b0, LW,  NO, 64'h1004, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'hFFFF_FFFF_FEDC_BA98, 1'b0, 1'b0, 3});
        vecs.push_back('{"lwu",  1'b1, 1'b0, LWU, NO, 64'h1004, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'h0000_0000_FEDC_BA98, 1'b0, 1'b0, 3});
        vecs.push_back('{"lw pos", 1'b1, 1'b0, LW, NO, 64'h1000, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'h0000_0000_7654_3210, 1'b0, 1'b0, 3});
        vecs.push_back('{"ld",   1'b1, 1'b0, LD,  NO, 64'h1008, Z, R, 1'b1, 64'h1008, Z, 8'h00, R, 1'b0, 1'b0, 3});
        vecs.push_back('{"lb pos", 1'b1, 1'b0, LB, NO, 64'h1000, Z, R, 1'b1, 64'h1000, Z, 8'h00, 64'h10, 1'b0, 1'b0, 3});
        vecs.push_back('{"sb",   1'b0, 1'b1, NO,  SB, 64'h2005, 64'h11AA, Z, 1'b1, 64'h2000, 64'h0011_AA00_0000_0000, 8'h20, Z, 1'b0, 1'b0, 2});
        vecs.push_back('{"sw",   1'b0, 1'b1, NO,  SW, 64'h2004, 64'hDEAD_BEEF, Z, 1'b1, 64'h2000, 64'hDEAD_BEEF_0000_0000, 8'hF0, Z, 1'b0, 1'b0, 2});
        vecs.push_back('{"sd",   1'b0, 1'b1, NO,  SD, 64'h2008, 64'h0123_4567_89AB_CDEF, Z, 1'b1, 64'h2008, 64'h0123_4567_89AB_CDEF, 8'hFF, Z, 1'b0, 1'b0, 2});
        vecs.push_back('{"lh mis", 1'b1, 1'b0, LH, NO, 64'h1001, Z, R, 1'b0, Z, Z, 8'h00, Z, 1'b1, 1'b0, 1});
        vecs.push_back('{"lhu mis", 1'b1, 1'b0, LHU, NO, 64'h1007, Z, R, 1'b0, Z, Z, 8'h00, Z, 1'b1, 1'b0, 1});
        vecs.push_back('{"sw mis", 1'b0, 1'b1, NO, SW, 64'h2006, 64'h99, Z, 1'b0, Z, Z, 8'h00, Z, 1'b1, 1'b0, 1});
        vecs.push_back('{"lt 000", 1'b1, 1'b0, NO, NO, 64'h1000, Z, R, 1'b0, Z, Z, 8'h00, Z, 1'b0, 1'b1, 1});
        vecs.push_back('{"st 000", 1'b0, 1'b1, NO, NO, 64'h2000, 64'h42, Z, 1'b0, Z, Z, 8'h00, Z, 1'b0, 1'b1, 1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_misalign", out_misalign, 1'b0);
        check("rst out_err", out_err, 1'b0);
        check("rst out_rdata", out_rdata, 64'h0);
        check("rst dmem_req", dmem_req, 1'b0);
        check("rst dmem_we", dmem_we, 1'b0);
        check("rst dmem_addr", dmem_addr, 64'h0);
        check("rst dmem_wdata", dmem_wdata, 64'h0);
        check("rst dmem_wmask", dmem_wmask, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of single accesses, zero memory wait
        foreach (vecs[i]) begin
            send(vecs[i]);
            wait_valid(vecs[i].exp_lat);
            wait_idle();
        end

        // ld with grant withheld 5 cycles and result back-pressured 3 cycles
        gnt_wait   = 5;
        out_ready  = 1'b0;
        req_cycles = 0;
        send('{"ld stall", 1'b1, 1'b0, LD, NO, 64'h1010, Z, 64'h0F1E_2D3C_4B5A_6978, 1'b1, 64'h1010, Z, 8'h00,
               64'h0F1E_2D3C_4B5A_6978, 1'b0, 1'b0, 0});
        wait_valid(0);
        for (int k = 0; k < 3; k++) begin
            check("stall in_ready", in_ready, 1'b0);
            check("stall out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
        check("stall req cycles", req_cycles, 6);
        gnt_wait = 0;

        // Reset while a request is outstanding
        gnt_wait = 1000;
        send('{"rst in REQ", 1'b1, 1'b0, LD, NO, 64'h1000, Z, R, 1'b1, 64'h1000, Z, 8'h00, R, 1'b0, 1'b0, 0});
        check("req before reset", dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("dmem_req drops on reset", dmem_req, 1'b0);
        exp_q.delete();
        req_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_wait = 0;
        check("post-reset in_ready", in_ready, 1'b1);
        check("post-reset out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("post-reset idle out_valid", out_valid, 1'b0);

        // Short-timeout instance: grant never arrives for a store
        cur_name   = "req timeout";
        mem_read   = 1'b0; mem_write = 1'b1; load_type = NO; store_type = SW;
        addr       = 64'h2004; wdata = 64'hCAFE_F00D;
        t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        check("t dmem_req", t_dmem_req, 1'b1);
        check("t dmem_addr", t_dmem_addr, 64'h2000);
        check("t dmem_we", t_dmem_we, 1'b1);
        check("t dmem_wdata", t_dmem_wdata, 64'hCAFE_F00D_0000_0000);
        check("t dmem_wmask", t_dmem_wmask, 8'hF0);
        t_wait_valid(n);
        check("t req timeout cycles", n, 4);
        check("t req timeout err", t_out_err, 1'b1);
        check("t req timeout dmem_req", t_dmem_req, 1'b0);
        check("t req timeout misalign", t_out_misalign, 1'b0);
        @(posedge clk); #1;
        check("t idle after req timeout", t_in_ready, 1'b1);

        // Grant given, read data never returns
        cur_name   = "resp timeout";
        mem_read   = 1'b1; mem_write = 1'b0; load_type = LD; store_type = NO;
        addr       = 64'h1000; wdata = '0;
        t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        t_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        t_dmem_gnt = 1'b0;
        t_wait_valid(n);
        check("t resp timeout cycles", n, 4);
        check("t resp timeout err", t_out_err, 1'b1);
        check("t resp timeout rdata", t_out_rdata, 64'h0);
        @(posedge clk); #1;
        check("t idle after resp timeout", t_in_ready, 1'b1);

        // Late read data arriving in IDLE is ignored
        cur_name      = "late rvalid";
        t_dmem_rvalid = 1'b1;
        t_dmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        @(posedge clk); #1;
        t_dmem_rvalid = 1'b0;
        check("t late rvalid out_valid", t_out_valid, 1'b0);
        check("t late rvalid in_ready", t_in_ready, 1'b1);

        // A normal load on the same instance completes cleanly afterwards
        cur_name   = "t ld after";
        addr       = 64'h1008;
        t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        t_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        t_dmem_gnt    = 1'b0;
        t_dmem_rvalid = 1'b1;
        t_dmem_rdata  = R;
        @(posedge clk); #1;
        t_dmem_rvalid = 1'b0;
        check("t ld out_valid", t_out_valid, 1'b1);
        check("t ld out_rdata", t_out_rdata, R);
        check("t ld out_err", t_out_err, 1'b0);
        @(posedge clk); #1;

        cur_name = "end";
        check("results outstanding", exp_q.size(), 0);
        check("requests outstanding", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
